throw_controller: RTL and testbench

THROW_CONTROLLER -- requirements
Module: throw_controller

---
 rtl/throw_controller.sv | 190 +++++++++++++++++++
 tb/tb_throw_controller.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/throw_controller.sv
// Throw sequencing for the two-player artillery game: aims, charges power
// from frame ticks, launches the projectile and holds the result for the turn counter.
module throw_controller #(
  parameter int POWER_MAX      = 63,
  parameter int FLIGHT_TIMEOUT = 240,
  parameter int RESULT_HOLD    = 60
) (
  input  logic       clk60MHz,
  input  logic       rst,
  input  logic [2:0] turn,
  input  logic       btn_cat,
  input  logic       btn_dog,
  input  logic       frame_tick,
  input  logic       proj_done,
  input  logic       proj_hit,
  input  logic       game_over,
  output logic       throw_flag,
  output logic       active_player,
  output logic [5:0] power,
  output logic       launch,
  output logic       hit_pulse,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] AIM       = 3'd1;
  localparam logic [2:0] CHARGE    = 3'd2;
  localparam logic [2:0] FLIGHT    = 3'd3;
  localparam logic [2:0] RESULT    = 3'd4;
  localparam logic [2:0] WAIT_TURN = 3'd5;

  localparam int CNT_MAX = (FLIGHT_TIMEOUT > RESULT_HOLD) ? FLIGHT_TIMEOUT : RESULT_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] FLIGHT_LAST = CNT_W'(FLIGHT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RESULT_LAST = CNT_W'(RESULT_HOLD - 1);
  localparam logic [5:0]       POWER_SAT   = 6'(POWER_MAX);

  logic [2:0]       state_r;
  logic [2:0]       state_nx_s;
  logic [2:0]       turn_lat_r;
  logic [CNT_W-1:0] frame_cnt_r;
  logic             cat_prev_r;
  logic             dog_prev_r;
  logic             act_btn_s;
  logic             act_prev_s;
  logic             act_rise_s;
  logic             act_fall_s;
  logic             load_turn_s;
  logic             charge_start_s;
  logic             power_inc_s;
  logic             flag_set_s;
  logic             flag_clr_s;
  logic             launch_nx_s;
  logic             hit_nx_s;

  function automatic logic [5:0] sat_inc(input logic [5:0] v);
    return (v >= POWER_SAT) ? v : v + 6'd1;
  endfunction

  // Only the owning player's button is ever looked at.
  assign act_btn_s  = active_player ? btn_dog : btn_cat;
  assign act_prev_s = active_player ? dog_prev_r : cat_prev_r;
  assign act_rise_s = act_btn_s & ~act_prev_s;
  assign act_fall_s = ~act_btn_s & act_prev_s;
  assign state_dbg  = state_r;

  // Next-state and per-transition action decode
  always_comb begin
    state_nx_s     = state_r;
    load_turn_s    = 1'b0;
    charge_start_s = 1'b0;
    power_inc_s    = 1'b0;
    flag_set_s     = 1'b0;
    flag_clr_s     = 1'b0;
    launch_nx_s    = 1'b0;
    hit_nx_s       = 1'b0;
    if (game_over) begin
      state_nx_s = IDLE;
      flag_clr_s = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          state_nx_s  = AIM;
          load_turn_s = 1'b1;
        end
        AIM: begin
          if (act_rise_s) begin
            state_nx_s     = CHARGE;
            charge_start_s = 1'b1;
          end else begin
            state_nx_s = AIM;
          end
        end
        CHARGE: begin
          if (act_fall_s) begin
            state_nx_s  = FLIGHT;
            launch_nx_s = 1'b1;
            flag_set_s  = 1'b1;
          end else if (frame_tick && act_btn_s) begin
            power_inc_s = 1'b1;
          end else begin
            state_nx_s = CHARGE;
          end
        end
        // A landing report on the timeout tick still counts as a landing.
        FLIGHT: begin
          if (proj_done) begin
            state_nx_s = RESULT;
            hit_nx_s   = proj_hit;
          end else if (frame_tick && (frame_cnt_r == FLIGHT_LAST)) begin
            state_nx_s = RESULT;
          end else begin
            state_nx_s = FLIGHT;
          end
        end
        RESULT: begin
          if (frame_tick && (frame_cnt_r == RESULT_LAST)) begin
            state_nx_s = WAIT_TURN;
            flag_clr_s = 1'b1;
          end else begin
            state_nx_s = RESULT;
          end
        end
        WAIT_TURN: begin
          if (turn != turn_lat_r) begin
            state_nx_s  = AIM;
            load_turn_s = 1'b1;
          end else begin
            state_nx_s = WAIT_TURN;
          end
        end
        default: begin
          state_nx_s = IDLE;
          flag_clr_s = 1'b1;
        end
      endcase
    end
  end

  // State, counters, edge detectors and registered outputs
  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      state_r       <= IDLE;
      turn_lat_r    <= 3'd0;
      frame_cnt_r   <= '0;
      cat_prev_r    <= 1'b0;
      dog_prev_r    <= 1'b0;
      throw_flag    <= 1'b0;
      active_player <= 1'b0;
      power         <= 6'd0;
      launch        <= 1'b0;
      hit_pulse     <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      cat_prev_r <= btn_cat;
      dog_prev_r <= btn_dog;
      launch     <= launch_nx_s;
      hit_pulse  <= hit_nx_s;
      if (state_nx_s != state_r) begin
        frame_cnt_r <= '0;
      end else if (frame_tick) begin
        frame_cnt_r <= frame_cnt_r + CNT_W'(1);
      end else begin
        frame_cnt_r <= frame_cnt_r;
      end
      if (flag_clr_s) begin
        throw_flag <= 1'b0;
      end else if (flag_set_s) begin
        throw_flag <= 1'b1;
      end else begin
        throw_flag <= throw_flag;
      end
      if (charge_start_s) begin
        power <= 6'd1;
      end else if (power_inc_s) begin
        power <= sat_inc(power);
      end else begin
        power <= power;
      end
      if (load_turn_s) begin
        active_player <= ~turn[0];
        turn_lat_r    <= turn;
      end else begin
        active_player <= active_player;
        turn_lat_r    <= turn_lat_r;
      end
    end
  end

endmodule

// File: tb/tb_throw_controller.sv
// Self-checking bench for throw_controller: table of directed throws, hand-written
// game_over / reset sequences, then random throws checked against a transaction model.
module tb_throw_controller;

  localparam int POWER_MAX = 63;

  logic       clk60MHz = 1'b0;
  logic       rst;
  logic [2:0] turn;
  logic       btn_cat, btn_dog, frame_tick, proj_done, proj_hit, game_over;
  logic       throw_flag, active_player, launch, hit_pulse;
  logic [5:0] power;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  int launch_seen = 0;
  int hit_seen = 0;

  typedef struct {
    logic [2:0] turn;
    int         hold;
    int         land;
    logic       hit;
    logic       exp_player;
    int         exp_power;
    logic       exp_hit;
  } vec_t;

  vec_t vecs [8];

  throw_controller dut (
    .clk60MHz(clk60MHz), .rst(rst), .turn(turn), .btn_cat(btn_cat), .btn_dog(btn_dog),
    .frame_tick(frame_tick), .proj_done(proj_done), .proj_hit(proj_hit), .game_over(game_over),
    .throw_flag(throw_flag), .active_player(active_player), .power(power), .launch(launch),
    .hit_pulse(hit_pulse), .state_dbg(state_dbg)
  );

  always #5 clk60MHz = ~clk60MHz;

  // Pulse counters sampled mid-cycle
  always @(negedge clk60MHz) begin
    if (launch === 1'b1) launch_seen++;
    if (hit_pulse === 1'b1) hit_seen++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk60MHz);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input string name);
    int waited = 0;
    while (state_dbg !== s && waited < 10) begin
      cyc();
      waited++;
    end
    chk(name, state_dbg, s);
  endtask

  task automatic poke_other(input logic pl);
    if (pl) btn_cat = 1'($urandom_range(0, 1));
    else    btn_dog = 1'($urandom_range(0, 1));
  endtask

  task automatic frame(input bit noise, input logic pl);
    int gap;
    frame_tick = 1'b1;
    if (noise) poke_other(pl);
    cyc();
    frame_tick = 1'b0;
    gap = $urandom_range(1, 3);
    for (int k = 0; k < gap; k++) begin
      if (noise) poke_other(pl);
      cyc();
    end
  endtask

  task automatic set_btn(input logic pl, input logic v);
    if (pl) btn_dog = v;
    else    btn_cat = v;
  endtask

  // One complete throw from WAIT_TURN/AIM through the end of RESULT.
  // land = 0 means no landing report (timeout), otherwise report on that frame tick.
  task automatic do_throw(input logic [2:0] t, input int hold, input int land, input logic hit,
                          input logic exp_player, input int exp_power, input logic exp_hit,
                          input bit noise);
    int l0, h0;
    l0 = launch_seen;
    h0 = hit_seen;
    turn = t;
    wait_state(3'd1, "reach_aim");
    chk("active_player", active_player, exp_player);
    set_btn(exp_player, 1'b1);
    cyc();
    chk("charge_entry", state_dbg, 3'd2);
    chk("power_start", power, 1);
    for (int i = 0; i < hold; i++) frame(noise, exp_player);
    btn_cat = 1'b0;
    btn_dog = 1'b0;
    cyc();
    chk("launch", launch, 1);
    chk("flight_entry", state_dbg, 3'd3);
    chk("throw_flag_up", throw_flag, 1);
    chk("power_final", power, exp_power);
    cyc();
    chk("launch_one_cycle", launch, 0);
    if (land == 0) begin
      for (int i = 0; i < 239; i++) frame(1'b0, exp_player);
      chk("flight_before_timeout", state_dbg, 3'd3);
      frame_tick = 1'b1;
      cyc();
      chk("timeout_result", state_dbg, 3'd4);
      chk("timeout_no_hit", hit_pulse, 0);
      frame_tick = 1'b0;
      cyc();
    end else begin
      for (int i = 0; i < land - 1; i++) frame(1'b0, exp_player);
      frame_tick = 1'b1;
      proj_done = 1'b1;
      proj_hit = hit;
      cyc();
      chk("land_result", state_dbg, 3'd4);
      chk("hit_pulse", hit_pulse, exp_hit);
      frame_tick = 1'b0;
      proj_done = 1'b0;
      proj_hit = 1'b0;
      cyc();
      chk("hit_one_cycle", hit_pulse, 0);
    end
    if (noise) begin
      proj_done = 1'b1;
      proj_hit = 1'b1;
      cyc();
      proj_done = 1'b0;
      proj_hit = 1'b0;
    end
    for (int i = 0; i < 59; i++) frame(1'b0, exp_player);
    chk("result_hold_flag", throw_flag, 1);
    chk("result_hold_state", state_dbg, 3'd4);
    frame_tick = 1'b1;
    cyc();
    chk("flag_drop", throw_flag, 0);
    chk("wait_turn", state_dbg, 3'd5);
    frame_tick = 1'b0;
    cyc();
    chk("launch_count", launch_seen - l0, 1);
    chk("hit_count", hit_seen - h0, 32'(exp_hit));
  endtask

  initial begin
    logic [2:0] t;
    int hold, land, sel, exp_power, l0, h0;
    logic hit, exp_player, exp_hit;

    vecs[0] = '{turn: 3'd1, hold: 5,   land: 3,   hit: 1'b1, exp_player: 1'b0, exp_power: 6,  exp_hit: 1'b1};
    vecs[1] = '{turn: 3'd2, hold: 100, land: 10,  hit: 1'b0, exp_player: 1'b1, exp_power: 63, exp_hit: 1'b0};
    vecs[2] = '{turn: 3'd3, hold: 0,   land: 0,   hit: 1'b1, exp_player: 1'b0, exp_power: 1,  exp_hit: 1'b0};
    vecs[3] = '{turn: 3'd4, hold: 62,  land: 240, hit: 1'b1, exp_player: 1'b1, exp_power: 63, exp_hit: 1'b1};
    vecs[4] = '{turn: 3'd5, hold: 61,  land: 1,   hit: 1'b1, exp_player: 1'b0, exp_power: 62, exp_hit: 1'b1};
    vecs[5] = '{turn: 3'd6, hold: 2,   land: 239, hit: 1'b0, exp_player: 1'b1, exp_power: 3,  exp_hit: 1'b0};
    vecs[6] = '{turn: 3'd7, hold: 1,   land: 5,   hit: 1'b1, exp_player: 1'b0, exp_power: 2,  exp_hit: 1'b1};
    vecs[7] = '{turn: 3'd0, hold: 3,   land: 2,   hit: 1'b1, exp_player: 1'b1, exp_power: 4,  exp_hit: 1'b1};

    rst = 1'b1;
    turn = 3'd1;
    btn_cat = 1'b0;
    btn_dog = 1'b0;
    frame_tick = 1'b0;
    proj_done = 1'b0;
    proj_hit = 1'b0;
    game_over = 1'b0;
    cyc();
    cyc();
    chk("rst_state", state_dbg, 3'd0);
    chk("rst_throw_flag", throw_flag, 0);
    chk("rst_launch", launch, 0);
    chk("rst_hit", hit_pulse, 0);
    chk("rst_power", power, 0);
    chk("rst_player", active_player, 0);
    rst = 1'b0;

    for (int v = 0; v < 8; v++)
      do_throw(vecs[v].turn, vecs[v].hold, vecs[v].land, vecs[v].hit,
               vecs[v].exp_player, vecs[v].exp_power, vecs[v].exp_hit, 1'b1);

    // game_over during CHARGE, then a button held across AIM re-entry
    turn = 3'd1;
    wait_state(3'd1, "go_reach_aim");
    btn_cat = 1'b1;
    cyc();
    chk("go_charge", state_dbg, 3'd2);
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    l0 = launch_seen;
    game_over = 1'b1;
    cyc();
    chk("go_idle", state_dbg, 3'd0);
    chk("go_flag", throw_flag, 0);
    repeat (4) cyc();
    chk("go_hold_idle", state_dbg, 3'd0);
    game_over = 1'b0;
    cyc();
    chk("go_release_aim", state_dbg, 3'd1);
    repeat (5) cyc();
    chk("held_btn_no_charge", state_dbg, 3'd1);
    btn_cat = 1'b0;
    cyc();
    cyc();
    chk("release_in_aim", state_dbg, 3'd1);
    chk("go_no_launch", launch_seen - l0, 0);

    // reset mid-FLIGHT, then landing reports outside FLIGHT are ignored
    btn_cat = 1'b1;
    cyc();
    btn_cat = 1'b0;
    cyc();
    chk("pre_rst_flight", state_dbg, 3'd3);
    frame(1'b0, 1'b0);
    h0 = hit_seen;
    l0 = launch_seen;
    rst = 1'b1;
    turn = 3'd2;
    proj_done = 1'b1;
    proj_hit = 1'b1;
    cyc();
    rst = 1'b0;
    proj_done = 1'b0;
    proj_hit = 1'b0;
    chk("rst_flight_state", state_dbg, 3'd0);
    chk("rst_flight_flag", throw_flag, 0);
    chk("rst_flight_power", power, 0);
    chk("rst_flight_player", active_player, 0);
    cyc();
    chk("post_rst_aim", state_dbg, 3'd1);
    chk("post_rst_player", active_player, 1);
    proj_done = 1'b1;
    proj_hit = 1'b1;
    cyc();
    proj_done = 1'b0;
    proj_hit = 1'b0;
    cyc();
    chk("done_outside_flight", state_dbg, 3'd1);
    chk("rst_no_pulses", (hit_seen - h0) + (launch_seen - l0), 0);

    // Random throws against the transaction model
    t = 3'd2;
    for (int r = 0; r < 12; r++) begin
      hold = $urandom_range(0, 70);
      sel  = $urandom_range(0, 3);
      land = (sel == 0) ? 0 : ((sel == 1) ? 240 : $urandom_range(1, 60));
      hit  = 1'($urandom_range(0, 1));
      exp_player = (int'(t) % 2 == 1) ? 1'b0 : 1'b1;
      exp_power  = (hold + 1 > POWER_MAX) ? POWER_MAX : hold + 1;
      exp_hit    = (land != 0) && hit;
      do_throw(t, hold, land, hit, exp_player, exp_power, exp_hit, 1'b1);
      t = t + 3'd1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
